dot_product_accumulator: RTL and testbench
==========================================

Name: dot_product_accumulator

Overview:
- Sequential accumulation stage that sits directly downstream of the 8-bit product/adder datapath in the matrix multiplication accelerator.
- Consumes a stream of DATA_W-bit partial products and adds each one, zero-extended, into an ACC_W-bit accumulator.
- After exactly K terms, presents the dot-product result on a valid/ready output port.
- Flags overflow of the accumulator width.

Parameters:
DATA_W, 8, width of each incoming product term (unsigned)
ACC_W, 16, accumulator/result width; must be >= DATA_W
K, 4, terms per dot product; legal range 1..255

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous flush of the accumulation in progress
in_valid  input  1  in_data holds a valid term
in_ready  output  1  block can accept a term this cycle
in_data  input  DATA_W  unsigned product term
out_valid  output  1  out_data holds a completed dot product
out_ready  input  1  consumer accepts the result this cycle
out_data  output  ACC_W  accumulated result
out_ovf  output  1  sticky: a carry out of ACC_W occurred during this result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset (rst_n low, any time, including mid-accumulation):
  - acc=0, cnt=0, state=ACC, out_valid=0, out_data=0, out_ovf=0.
  - in_ready=1 once clear is low.
- States:
  - ACC: collecting terms; cnt holds the number of terms accepted so far (0..K-1).
  - DONE: result held on outputs.
- Handshake:
  - An input is accepted when in_valid && in_ready at a rising edge.
  - A result is taken when out_valid && out_ready at a rising edge.
- in_ready is combinational: in_ready = !clear && (state==ACC || out_ready).
- out_valid = (state==DONE). out_data and out_ovf are driven directly from registers and stay stable while out_valid && !out_ready.
- ACC state, on accept:
  - acc <= acc + zext(in_data); cnt <= cnt+1.
  - If cnt==K-1: cnt <= 0 and state <= DONE. out_valid rises the cycle after the K-th accept (latency 1).
- DONE state:
  - out_ready low: hold everything; in_ready=0.
  - Result taken with no simultaneous input: acc, ovf, cnt <= 0; state <= ACC.
  - Result taken with a simultaneous input accept: acc <= zext(in_data), ovf <= 0, cnt <= 1, state <= ACC. This gives zero bubble; steady-state throughput is one result per K cycles.
  - Special case K==1 with a simultaneous accept: stay in DONE, with out_data = zext(in_data) on the next cycle.
- Arithmetic:
  - Unsigned addition. The carry out of bit ACC_W-1 sets ovf (sticky until the result is taken, clear, or reset).
  - Default behaviour is to wrap modulo 2^ACC_W.
- Clear (synchronous, priority over all handshakes):
  - acc=0, cnt=0, ovf=0, state=ACC, out_valid=0.
  - An input presented in the same cycle is not accepted (in_ready=0).
  - A held result is discarded.
- in_valid low during ACC: no state change, and no timeout.

Optional Feature:
- Macro: ACC_SATURATE_EN.
- Defined: on any add that produces a carry out of ACC_W, acc <= all-ones (2^ACC_W-1) and ovf <= 1. Later adds within the same result leave acc at all-ones.
- Undefined: wrap-around as described in Behaviour; ovf is still flagged.

Test Plan:
- Reset mid-run: accept 10,20; assert rst_n low for 2 cycles -> out_valid=0, out_data=0, out_ovf=0; after release in_ready=1; then 1,2,3,4 -> out_data=10.
- Basic: K=4, out_ready=1, back-to-back 10,20,30,40 -> out_valid high exactly one cycle after the 4th accept, out_data=100, out_ovf=0.
- Backpressure: complete 5,5,5,5 with out_ready low for 3 cycles:
  - out_valid=1, out_data=20, in_ready=0 held all 3 cycles.
  - out_ready=1 -> handshake completes, and the next terms accumulate from 0.
- Overflow: ACC_W=9, K=4, four terms of 255:
  - without the macro -> out_data=508, out_ovf=1.
  - with ACC_SATURATE_EN -> out_data=511, out_ovf=1.
- Streaming: eight consecutive terms of 1, in_valid and out_ready held high:
  - two results of 4 with no idle input cycle.
  - the 5th term is accepted in the same edge as the first result handshake.
  - second result out_ovf=0.
- Clear: accept 7,9, pulse clear with in_valid=1 and in_data=99 -> 99 not accepted; then 5,5,5,5 -> out_data=20.

Source files
------------

// File: rtl/dot_product_accumulator_if.sv
// Stream interface for dot_product_accumulator: term input, result output and flush.
interface dot_product_accumulator_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic              out_ovf;

  modport master (
    output clear, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  clear, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Accumulates K unsigned terms into an ACC_W result with sticky overflow flag.
// Define ACC_SATURATE_EN to clamp at all-ones on overflow instead of wrapping.
//
// state   | meaning
// ST_ACC  | collecting terms, cnt_q = terms accepted so far (0..K-1)
// ST_DONE | result held on out_data/out_ovf until taken
module dot_product_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int K      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dot_product_accumulator_if.slave   bus
);

  typedef enum logic {ST_ACC, ST_DONE} state_t;

  localparam logic [7:0] CNT_LAST = 8'(K - 1);

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [ACC_W-1:0] term_ext;
  logic             accept;
  logic             take;

  assign term_ext = ACC_W'(bus.in_data);
  assign sum      = {1'b0, acc_q} + {1'b0, term_ext};
  assign carry    = sum[ACC_W];

`ifdef ACC_SATURATE_EN
  // once saturated, any further add carries again (or adds zero) and stays clamped
  assign acc_add = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_add = sum[ACC_W-1:0];
`endif

  assign bus.in_ready  = !bus.clear && (state_q == ST_ACC || bus.out_ready);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.out_data  = acc_q;
  assign bus.out_ovf   = ovf_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign take   = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (bus.clear) begin
      state_d = ST_ACC;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (accept) begin
            acc_d = acc_add;
            ovf_d = ovf_q | carry;
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = ST_DONE;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (take) begin
            ovf_d = 1'b0;
            if (accept) begin
              // the incoming term starts the next result with no bubble
              acc_d = term_ext;
              if (K == 1) begin
                cnt_d   = '0;
                state_d = ST_DONE;
              end else begin
                cnt_d   = 8'd1;
                state_d = ST_ACC;
              end
            end else begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_ACC;
            end
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dot_product_accumulator.sv
// Scoreboard bench for dot_product_accumulator (default K=4/ACC_W=16 plus an ACC_W=9 overflow instance).
module tb_dot_product_accumulator;

  typedef struct packed {
    logic [15:0] data;
    logic        ovf;
  } result_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   n_pushed;
  int   n_results;
  int   cyc;

  result_t     sb_q[$];
  logic [15:0] model_acc;
  logic        model_ovf;
  int          model_cnt;

  dot_product_accumulator_if #(.DATA_W(8), .ACC_W(16)) bus ();
  dot_product_accumulator_if #(.DATA_W(8), .ACC_W(9))  ob ();

  dot_product_accumulator #(.DATA_W(8), .ACC_W(16), .K(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dot_product_accumulator #(.DATA_W(8), .ACC_W(9), .K(4)) u_ovf (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ob.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    model_acc = '0;
    model_ovf = 1'b0;
    model_cnt = 0;
  endtask

  task automatic model_accept(input logic [7:0] d);
    logic [16:0] s;
    result_t     r;
    s = {1'b0, model_acc} + 17'(d);
    model_ovf = model_ovf | s[16];
`ifdef ACC_SATURATE_EN
    model_acc = s[16] ? 16'hFFFF : s[15:0];
`else
    model_acc = s[15:0];
`endif
    model_cnt++;
    if (model_cnt == 4) begin
      r.data = model_acc;
      r.ovf  = model_ovf;
      sb_q.push_back(r);
      n_pushed++;
      model_reset();
    end
  endtask

  // present a term and hold it until accepted; leaves in_valid high
  task automatic put(input logic [7:0] d);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(d);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("put_timeout", 32'd0, 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_results++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        result_t r;
        r = sb_q.pop_front();
        chk("sb_data", 32'(bus.out_data), 32'(r.data));
        chk("sb_ovf", 32'(bus.out_ovf), 32'(r.ovf));
      end
    end
  end

  initial begin
    int c0;
    n_checks = 0; n_errors = 0; n_pushed = 0; n_results = 0; cyc = 0;
    model_reset();
    rst_n = 1'b0;
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
    ob.clear  = 1'b0; ob.in_valid  = 1'b0; ob.in_data  = '0; ob.out_ready  = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ovf", 32'(bus.out_ovf), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // basic: back-to-back terms, latency of one cycle after the 4th accept
    put(8'd10); put(8'd20); put(8'd30);
    chk("basic_not_yet_valid", 32'(bus.out_valid), 32'd0);
    put(8'd40);
    bus.in_valid = 1'b0;
    chk("basic_valid_after_4th", 32'(bus.out_valid), 32'd1);
    chk("basic_data", 32'(bus.out_data), 32'd100);
    step();
    chk("basic_valid_drops", 32'(bus.out_valid), 32'd0);

    // backpressure: result held for 3 cycles with input blocked
    bus.out_ready = 1'b0;
    put(8'd5); put(8'd5); put(8'd5); put(8'd5);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_data", 32'(bus.out_data), 32'd20);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    put(8'd1); put(8'd2); put(8'd3); put(8'd4);
    bus.in_valid = 1'b0;
    step();

    // streaming: eight terms, no idle input cycle, 5th accepted with first handshake
    c0 = cyc;
    put(8'd1); put(8'd1); put(8'd1); put(8'd1);
    chk("stream_result1_valid", 32'(bus.out_valid), 32'd1);
    put(8'd1);
    chk("stream_5th_no_result", 32'(bus.out_valid), 32'd0);
    put(8'd1); put(8'd1); put(8'd1);
    chk("stream_cycles", 32'(cyc - c0), 32'd8);
    bus.in_valid = 1'b0;
    step();
    chk("stream_two_results", 32'(n_results), 32'd5);

    // clear: in-flight 7,9 flushed, 99 presented with clear not taken
    put(8'd7); put(8'd9);
    bus.clear = 1'b1;
    bus.in_data = 8'd99;
    #1;
    chk("clr_in_ready", 32'(bus.in_ready), 32'd0);
    step();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    chk("clr_out_valid", 32'(bus.out_valid), 32'd0);
    put(8'd5); put(8'd5); put(8'd5); put(8'd5);
    bus.in_valid = 1'b0;
    step();

    // reset mid-run
    put(8'd10); put(8'd20);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    step(); step();
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_data", 32'(bus.out_data), 32'd0);
    chk("mrst_out_ovf", 32'(bus.out_ovf), 32'd0);
    rst_n = 1'b1;
    step();
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    put(8'd1); put(8'd2); put(8'd3); put(8'd4);
    bus.in_valid = 1'b0;
    step();

    // overflow on the 9-bit instance
    ob.in_valid = 1'b1;
    ob.in_data  = 8'd255;
    repeat (4) step();
    ob.in_valid = 1'b0;
    chk("ovf_valid", 32'(ob.out_valid), 32'd1);
`ifdef ACC_SATURATE_EN
    chk("ovf_data", 32'(ob.out_data), 32'd511);
`else
    chk("ovf_data", 32'(ob.out_data), 32'd508);
`endif
    chk("ovf_flag", 32'(ob.out_ovf), 32'd1);
    ob.out_ready = 1'b1;
    step();
    chk("ovf_taken_valid", 32'(ob.out_valid), 32'd0);
    chk("ovf_taken_flag", 32'(ob.out_ovf), 32'd0);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    chk("result_count", 32'(n_results), 32'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
